fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core. Owns the PC, issues

---
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register: PC, req/gnt/rvalid fetch port, response FIFO.
// Optional perf counters built when FETCH_PERF_CNT_EN is defined; otherwise outputs tie to 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite_en_i,
  input  logic        IF_ID_write_en_i,
  input  logic        EX_branch_taken_i,
  input  logic [31:0] EX_branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] IF_ID_pc_o,
  output logic [31:0] IF_ID_pc_plus4_o,
  output logic [31:0] IF_ID_instr_o,
  output logic        IF_ID_valid_o,
  output logic [31:0] fetch_stall_cnt_o,
  output logic [31:0] fetch_flush_cnt_o
);

  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PCQ_AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

  logic [31:0]       pc_q, pc_d;
  logic [OUT_W-1:0]  out_q, out_d, drop_q, drop_d;
  fifo_entry_t       fifo_mem_q [FIFO_DEPTH];
  fifo_entry_t       fifo_mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [31:0]       pcq_mem_q [MAX_OUTSTANDING];
  logic [31:0]       pcq_mem_d [MAX_OUTSTANDING];
  logic [PCQ_AW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [31:0]       if_id_pc_q, if_id_pc_d, if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic              credit_ok, issue, rsp_keep, fifo_push, fifo_pop;

  function automatic logic [PCQ_AW-1:0] pcq_inc(input logic [PCQ_AW-1:0] p);
    return (p == PCQ_AW'(MAX_OUTSTANDING - 1)) ? '0 : p + PCQ_AW'(1);
  endfunction

  always_comb begin
    fifo_pop   = ~EX_branch_taken_i & IF_ID_write_en_i & (fifo_cnt_q != '0);
    // A pop this cycle frees its slot, so depth 2 still sustains one fetch per cycle.
    credit_ok  = (32'(out_q) + 32'(fifo_cnt_q) - 32'(fifo_pop) < FIFO_DEPTH) &&
                 (32'(out_q) < MAX_OUTSTANDING);
    imem_req_o = ~rst & PCWrite_en_i & ~EX_branch_taken_i & credit_ok;
    issue      = imem_req_o & imem_gnt_i;
    rsp_keep   = imem_rvalid_i & (drop_q == '0);
    fifo_push  = rsp_keep & ~EX_branch_taken_i;
  end

  always_comb begin
    pc_d = pc_q;
    if (EX_branch_taken_i)  pc_d = EX_branch_target_i & 32'hFFFF_FFFC;
    else if (issue)         pc_d = pc_q + 32'd4;

    out_d  = out_q + OUT_W'(issue) - OUT_W'(imem_rvalid_i);
    drop_d = drop_q;
    if (imem_rvalid_i && drop_q != '0) drop_d = drop_q - OUT_W'(1);

    pcq_mem_d = pcq_mem_q;
    pcq_wr_d  = pcq_wr_q;
    pcq_rd_d  = pcq_rd_q;
    if (issue) begin
      pcq_mem_d[pcq_wr_q] = pc_q;
      pcq_wr_d            = pcq_inc(pcq_wr_q);
    end
    if (rsp_keep) pcq_rd_d = pcq_inc(pcq_rd_q);

    fifo_mem_d = fifo_mem_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    if (fifo_push) begin
      fifo_mem_d[fifo_wr_q] = '{pc: pcq_mem_q[pcq_rd_q], instr: imem_rdata_i};
      fifo_wr_d             = fifo_wr_q + FIFO_AW'(1);
    end
    if (fifo_pop) fifo_rd_d = fifo_rd_q + FIFO_AW'(1);

    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (EX_branch_taken_i) begin
      // Words still in flight belong to the old path; drop them as they return.
      drop_d        = out_d;
      pcq_wr_d      = '0;
      pcq_rd_d      = '0;
      fifo_wr_d     = '0;
      fifo_rd_d     = '0;
      fifo_cnt_d    = '0;
      if_id_instr_d = NOP;
      if_id_valid_d = 1'b0;
    end else if (IF_ID_write_en_i) begin
      if (fifo_pop) begin
        if_id_pc_d    = fifo_mem_q[fifo_rd_q].pc;
        if_id_instr_d = fifo_mem_q[fifo_rd_q].instr;
        if_id_valid_d = 1'b1;
      end else begin
        if_id_instr_d = NOP;
        if_id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      out_q         <= '0;
      drop_q        <= '0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      fifo_cnt_q    <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)      fifo_mem_q[i] <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) pcq_mem_q[i]  <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      out_q         <= out_d;
      drop_q        <= drop_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      fifo_mem_q    <= fifo_mem_d;
      pcq_mem_q     <= pcq_mem_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid_i |-> (out_q != '0));

  assign imem_addr_o      = pc_q;
  assign IF_ID_pc_o       = if_id_pc_q;
  assign IF_ID_pc_plus4_o = if_id_pc_q + 32'd4;
  assign IF_ID_instr_o    = if_id_instr_q;
  assign IF_ID_valid_o    = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (EX_branch_taken_i)                            flush_cnt_d = flush_cnt_q + 32'd1;
    else if (IF_ID_write_en_i && fifo_cnt_q == '0)    stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_stall_cnt_o = stall_cnt_q;
  assign fetch_flush_cnt_o = flush_cnt_q;
`else
  assign fetch_stall_cnt_o = '0;
  assign fetch_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with an in-order memory model (words = addr ^ WORD_XOR).
module tb_fetch_stage;

  localparam logic [31:0] WORD_XOR = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCWrite_en_i = 1'b1, IF_ID_write_en_i = 1'b1, EX_branch_taken_i = 1'b0;
  logic [31:0] EX_branch_target_i = '0;
  logic        imem_req_o, imem_gnt_i = 1'b1, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] IF_ID_pc_o, IF_ID_pc_plus4_o, IF_ID_instr_o;
  logic        IF_ID_valid_o;
  logic [31:0] fetch_stall_cnt_o, fetch_flush_cnt_o;

  logic        resp_hold = 1'b0;
  logic [31:0] mem_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_stage #(
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .PCWrite_en_i      (PCWrite_en_i),
    .IF_ID_write_en_i  (IF_ID_write_en_i),
    .EX_branch_taken_i (EX_branch_taken_i),
    .EX_branch_target_i(EX_branch_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .IF_ID_pc_o        (IF_ID_pc_o),
    .IF_ID_pc_plus4_o  (IF_ID_pc_plus4_o),
    .IF_ID_instr_o     (IF_ID_instr_o),
    .IF_ID_valid_o     (IF_ID_valid_o),
    .fetch_stall_cnt_o (fetch_stall_cnt_o),
    .fetch_flush_cnt_o (fetch_flush_cnt_o)
  );

  always #5 clk = ~clk;

  // In-order memory: answers the oldest granted address one cycle after grant unless held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q.delete();
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= '0;
    end else begin
      if (imem_req_o && imem_gnt_i) mem_q.push_back(imem_addr_o);
      if (!resp_hold && mem_q.size() != 0) begin
        imem_rvalid_i <= 1'b1;
        imem_rdata_i  <= mem_q.pop_front() ^ WORD_XOR;
      end else begin
        imem_rvalid_i <= 1'b0;
      end
    end
  end

  // Returns at a falling edge with reset just released: that cycle is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    PCWrite_en_i = 1'b1; IF_ID_write_en_i = 1'b1; EX_branch_taken_i = 1'b0;
    EX_branch_target_i = '0; imem_gnt_i = 1'b1; resp_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++; if (imem_addr_o !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr k=%0d: got %h expected %h", k, imem_addr_o, 32'(4 * k)); end
      n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL seq_req k=%0d: got %b expected 1", k, imem_req_o); end
      if (k >= 3) begin
        exp_pc = 32'(4 * (k - 3));
        n_checks++; if (IF_ID_valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid k=%0d: got %b expected 1", k, IF_ID_valid_o); end
        n_checks++; if (IF_ID_pc_o !== exp_pc) begin n_fail++; $display("FAIL seq_pc k=%0d: got %h expected %h", k, IF_ID_pc_o, exp_pc); end
        n_checks++; if (IF_ID_instr_o !== (exp_pc ^ WORD_XOR)) begin n_fail++; $display("FAIL seq_instr k=%0d: got %h expected %h", k, IF_ID_instr_o, exp_pc ^ WORD_XOR); end
        n_checks++; if (IF_ID_pc_plus4_o !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_pc4 k=%0d: got %h expected %h", k, IF_ID_pc_plus4_o, exp_pc + 32'd4); end
      end else begin
        n_checks++; if (IF_ID_valid_o !== 1'b0 || IF_ID_instr_o !== NOP) begin n_fail++; $display("FAIL seq_bubble k=%0d: got valid=%b instr=%h expected valid=0 instr=%h", k, IF_ID_valid_o, IF_ID_instr_o, NOP); end
      end
    end
    n_checks++; if (fetch_stall_cnt_o !== (PERF ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL seq_stall_cnt: got %0d expected %0d", fetch_stall_cnt_o, PERF ? 2 : 0); end
    n_checks++; if (fetch_flush_cnt_o !== 32'd0) begin n_fail++; $display("FAIL seq_flush_cnt: got %0d expected 0", fetch_flush_cnt_o); end
  endtask

  // Asserted while requests and responses are in flight.
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (IF_ID_pc_o !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", IF_ID_pc_o); end
    n_checks++; if (IF_ID_pc_plus4_o !== 32'd4) begin n_fail++; $display("FAIL rst_pc4: got %h expected 4", IF_ID_pc_plus4_o); end
    n_checks++; if (IF_ID_instr_o !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h expected %h", IF_ID_instr_o, NOP); end
    n_checks++; if (IF_ID_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", IF_ID_valid_o); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'd0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", imem_addr_o); end
    n_checks++; if (fetch_stall_cnt_o !== 32'd0 || fetch_flush_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_cnts: got %0d/%0d expected 0/0", fetch_stall_cnt_o, fetch_flush_cnt_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (IF_ID_valid_o !== (k >= 3)) begin n_fail++; $display("FAIL rst_after_valid k=%0d: got %b expected %b", k, IF_ID_valid_o, k >= 3); end
      if (k >= 3) begin
        n_checks++; if (IF_ID_pc_o !== 32'(4 * (k - 3))) begin n_fail++; $display("FAIL rst_after_pc k=%0d: got %h expected %h", k, IF_ID_pc_o, 32'(4 * (k - 3))); end
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        exp_pc = (k <= 5) ? 32'(4 * (k - 3)) : 32'(4 * (k - 4));
        n_checks++; if (IF_ID_valid_o !== 1'b1 || IF_ID_pc_o !== exp_pc) begin n_fail++; $display("FAIL lu_pc k=%0d: got valid=%b pc=%h expected valid=1 pc=%h", k, IF_ID_valid_o, IF_ID_pc_o, exp_pc); end
        n_checks++; if (IF_ID_instr_o !== (exp_pc ^ WORD_XOR)) begin n_fail++; $display("FAIL lu_instr k=%0d: got %h expected %h", k, IF_ID_instr_o, exp_pc ^ WORD_XOR); end
      end
      if (k == 5) begin
        PCWrite_en_i = 1'b0; IF_ID_write_en_i = 1'b0;
        #1;
        n_checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h14) begin n_fail++; $display("FAIL lu_hold_req: got req=%b addr=%h expected req=0 addr=00000014", imem_req_o, imem_addr_o); end
      end
      if (k == 6) begin
        PCWrite_en_i = 1'b1; IF_ID_write_en_i = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14) begin n_fail++; $display("FAIL lu_resume_req: got req=%b addr=%h expected req=1 addr=00000014", imem_req_o, imem_addr_o); end
      end
    end
    n_checks++; if (fetch_stall_cnt_o !== (PERF ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected %0d", fetch_stall_cnt_o, PERF ? 2 : 0); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    resp_hold = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL rd_second_req: got req=%b addr=%h expected req=1 addr=00000004", imem_req_o, imem_addr_o); end
    @(negedge clk);
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rd_max_outstanding: got req=%b expected 0", imem_req_o); end
    EX_branch_taken_i = 1'b1; EX_branch_target_i = 32'h100;
    @(negedge clk);
    n_checks++; if (IF_ID_valid_o !== 1'b0 || IF_ID_instr_o !== NOP) begin n_fail++; $display("FAIL rd_flush: got valid=%b instr=%h expected valid=0 instr=%h", IF_ID_valid_o, IF_ID_instr_o, NOP); end
    EX_branch_taken_i = 1'b0; resp_hold = 1'b0;
    #1;
    n_checks++; if (imem_addr_o !== 32'h100 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rd_target: got req=%b addr=%h expected req=0 addr=00000100", imem_req_o, imem_addr_o); end
    for (int k = 4; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        n_checks++; if (IF_ID_valid_o !== 1'b0) begin n_fail++; $display("FAIL rd_bubble k=%0d: got valid=%b pc=%h expected valid=0", k, IF_ID_valid_o, IF_ID_pc_o); end
      end
      if (k == 5) begin
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rd_first_req: got req=%b addr=%h expected req=1 addr=00000100", imem_req_o, imem_addr_o); end
      end
      if (k >= 8) begin
        n_checks++; if (IF_ID_valid_o !== 1'b1 || IF_ID_pc_o !== 32'(32'h100 + 4 * (k - 8))) begin n_fail++; $display("FAIL rd_new_pc k=%0d: got valid=%b pc=%h expected valid=1 pc=%h", k, IF_ID_valid_o, IF_ID_pc_o, 32'(32'h100 + 4 * (k - 8))); end
        n_checks++; if (IF_ID_instr_o !== (32'(32'h100 + 4 * (k - 8)) ^ WORD_XOR)) begin n_fail++; $display("FAIL rd_new_instr k=%0d: got %h expected %h", k, IF_ID_instr_o, 32'(32'h100 + 4 * (k - 8)) ^ WORD_XOR); end
      end
    end
    n_checks++; if (fetch_flush_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL rd_flush_cnt: got %0d expected %0d", fetch_flush_cnt_o, PERF ? 1 : 0); end
    n_checks++; if (fetch_stall_cnt_o !== (PERF ? 32'd6 : 32'd0)) begin n_fail++; $display("FAIL rd_stall_cnt: got %0d expected %0d", fetch_stall_cnt_o, PERF ? 6 : 0); end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    imem_gnt_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 5) begin
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL gs_addr k=%0d: got req=%b addr=%h expected req=1 addr=00000000", k, imem_req_o, imem_addr_o); end
      end
      if (k == 5) begin
        n_checks++; if (fetch_stall_cnt_o !== (PERF ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL gs_stall_cnt5: got %0d expected %0d", fetch_stall_cnt_o, PERF ? 5 : 0); end
        imem_gnt_i = 1'b1;
      end
      if (k <= 7) begin
        n_checks++; if (IF_ID_valid_o !== 1'b0) begin n_fail++; $display("FAIL gs_bubble k=%0d: got %b expected 0", k, IF_ID_valid_o); end
      end else begin
        n_checks++; if (IF_ID_valid_o !== 1'b1 || IF_ID_pc_o !== 32'(4 * (k - 8))) begin n_fail++; $display("FAIL gs_pc k=%0d: got valid=%b pc=%h expected valid=1 pc=%h", k, IF_ID_valid_o, IF_ID_pc_o, 32'(4 * (k - 8))); end
      end
      if (k == 8) begin
        n_checks++; if (fetch_stall_cnt_o !== (PERF ? 32'd7 : 32'd0)) begin n_fail++; $display("FAIL gs_stall_cnt8: got %0d expected %0d", fetch_stall_cnt_o, PERF ? 7 : 0); end
      end
    end
  endtask

  // Redirect during a full stall, with a misaligned target.
  task automatic test_redirect_hold();
    do_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (IF_ID_pc_o !== 32'h8 || IF_ID_valid_o !== 1'b1) begin n_fail++; $display("FAIL rh_pre_pc: got valid=%b pc=%h expected valid=1 pc=00000008", IF_ID_valid_o, IF_ID_pc_o); end
    EX_branch_taken_i = 1'b1; EX_branch_target_i = 32'h203;
    PCWrite_en_i = 1'b0; IF_ID_write_en_i = 1'b0;
    #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rh_req_in_redirect: got %b expected 0", imem_req_o); end
    @(negedge clk);
    n_checks++; if (IF_ID_valid_o !== 1'b0 || IF_ID_instr_o !== NOP) begin n_fail++; $display("FAIL rh_flush: got valid=%b instr=%h expected valid=0 instr=%h", IF_ID_valid_o, IF_ID_instr_o, NOP); end
    EX_branch_taken_i = 1'b0; PCWrite_en_i = 1'b1; IF_ID_write_en_i = 1'b1;
    #1;
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL rh_target: got req=%b addr=%h expected req=1 addr=00000200", imem_req_o, imem_addr_o); end
    for (int k = 7; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        n_checks++; if (IF_ID_valid_o !== 1'b0) begin n_fail++; $display("FAIL rh_bubble k=%0d: got %b expected 0", k, IF_ID_valid_o); end
      end else begin
        n_checks++; if (IF_ID_valid_o !== 1'b1 || IF_ID_pc_o !== 32'(32'h200 + 4 * (k - 9))) begin n_fail++; $display("FAIL rh_pc k=%0d: got valid=%b pc=%h expected valid=1 pc=%h", k, IF_ID_valid_o, IF_ID_pc_o, 32'(32'h200 + 4 * (k - 9))); end
        n_checks++; if (IF_ID_instr_o !== (32'(32'h200 + 4 * (k - 9)) ^ WORD_XOR)) begin n_fail++; $display("FAIL rh_instr k=%0d: got %h expected %h", k, IF_ID_instr_o, 32'(32'h200 + 4 * (k - 9)) ^ WORD_XOR); end
      end
    end
    n_checks++; if (fetch_flush_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL rh_flush_cnt: got %0d expected %0d", fetch_flush_cnt_o, PERF ? 1 : 0); end
    n_checks++; if (fetch_stall_cnt_o !== (PERF ? 32'd4 : 32'd0)) begin n_fail++; $display("FAIL rh_stall_cnt: got %0d expected %0d", fetch_stall_cnt_o, PERF ? 4 : 0); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    EX_branch_taken_i = 1'b1; EX_branch_target_i = 32'hFFFF_FFFC;
    #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL wr_req_in_redirect: got %b expected 0", imem_req_o); end
    @(negedge clk);
    EX_branch_taken_i = 1'b0;
    #1;
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_top_addr: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req_o, imem_addr_o); end
    @(negedge clk);
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wr_wrap_addr: got req=%b addr=%h expected req=1 addr=00000000", imem_req_o, imem_addr_o); end
    @(negedge clk);
    n_checks++; if (IF_ID_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr_bubble: got %b expected 0", IF_ID_valid_o); end
    @(negedge clk);
    n_checks++; if (IF_ID_valid_o !== 1'b1 || IF_ID_pc_o !== 32'hFFFF_FFFC || IF_ID_pc_plus4_o !== 32'h0) begin n_fail++; $display("FAIL wr_top_pc: got valid=%b pc=%h pc4=%h expected valid=1 pc=fffffffc pc4=00000000", IF_ID_valid_o, IF_ID_pc_o, IF_ID_pc_plus4_o); end
    n_checks++; if (IF_ID_instr_o !== (32'hFFFF_FFFC ^ WORD_XOR)) begin n_fail++; $display("FAIL wr_top_instr: got %h expected %h", IF_ID_instr_o, 32'hFFFF_FFFC ^ WORD_XOR); end
    n_checks++; if (fetch_stall_cnt_o !== (PERF ? 32'd2 : 32'd0) || fetch_flush_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL wr_cnts: got stall=%0d flush=%0d expected stall=%0d flush=%0d", fetch_stall_cnt_o, fetch_flush_cnt_o, PERF ? 2 : 0, PERF ? 1 : 0); end
    @(negedge clk);
    n_checks++; if (IF_ID_valid_o !== 1'b1 || IF_ID_pc_o !== 32'h0 || IF_ID_pc_plus4_o !== 32'h4) begin n_fail++; $display("FAIL wr_zero_pc: got valid=%b pc=%h pc4=%h expected valid=1 pc=00000000 pc4=00000004", IF_ID_valid_o, IF_ID_pc_o, IF_ID_pc_plus4_o); end
  endtask

  initial begin
    #1;
    test_sequential();
    test_reset();
    test_load_use();
    test_redirect_drop();
    test_gnt_stall();
    test_redirect_hold();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
